// File: rtl/ahb_master_arbiter_2x1.sv
// Two-master AHB-Lite arbiter: shares one system-bus slave path between the
// core (M0) and a second master (M1). A master that loses arbitration is
// captured into a pend buffer, stalled via its HREADY and replayed later.
module ahb_master_arbiter_2x1 #(
    parameter int unsigned AW       = 32,
    parameter int unsigned DW       = 64,
    parameter int unsigned ARB_MODE = 1
) (
    input  logic          HCLK,
    input  logic          HRESETn,
    input  logic [AW-1:0] HADDR_M0,
    input  logic [1:0]    HTRANS_M0,
    input  logic          HWRITE_M0,
    input  logic [2:0]    HSIZE_M0,
    input  logic [DW-1:0] HWDATA_M0,
    output logic          HREADY_M0,
    output logic [DW-1:0] HRDATA_M0,
    input  logic [AW-1:0] HADDR_M1,
    input  logic [1:0]    HTRANS_M1,
    input  logic          HWRITE_M1,
    input  logic [2:0]    HSIZE_M1,
    input  logic [DW-1:0] HWDATA_M1,
    output logic          HREADY_M1,
    output logic [DW-1:0] HRDATA_M1,
    output logic [AW-1:0] HADDR_S,
    output logic [1:0]    HTRANS_S,
    output logic          HWRITE_S,
    output logic [2:0]    HSIZE_S,
    output logic [DW-1:0] HWDATA_S,
    input  logic          HREADY_S,
    input  logic [DW-1:0] HRDATA_S,
    output logic          HMASTER_S
);

    typedef struct packed {
        logic [AW-1:0] addr;
        logic          write;
        logic [2:0]    size;
    } aphase_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_M0   = 2'd1,
        OWN_M1   = 2'd2
    } owner_e;

    aphase_t     live_c [2];
    aphase_t     pend_q [2];
    aphase_t     sel_c;
    logic [1:0]  pend_valid_q;
    owner_e      owner_q;
    logic        last_grant_q;
    logic [1:0]  hready_m_c;
    logic [1:0]  acc_c;
    logic [1:0]  req_c;
    logic        issue_c;
    logic        issue_id_c;

    // Only HTRANS[1] qualifies a transfer; IDLE and BUSY look the same here.
    logic unused_trans_lsb;
    assign unused_trans_lsb = HTRANS_M0[0] ^ HTRANS_M1[0];

    // Live address phases, per-master ready, acceptance and request.
    always_comb begin
        live_c[0]     = '{addr: HADDR_M0, write: HWRITE_M0, size: HSIZE_M0};
        live_c[1]     = '{addr: HADDR_M1, write: HWRITE_M1, size: HSIZE_M1};
        hready_m_c[0] = (owner_q == OWN_M0) ? HREADY_S : ~pend_valid_q[0];
        hready_m_c[1] = (owner_q == OWN_M1) ? HREADY_S : ~pend_valid_q[1];
        acc_c         = {HTRANS_M1[1] & hready_m_c[1], HTRANS_M0[1] & hready_m_c[0]};
        req_c         = pend_valid_q | acc_c;
    end

    // Grant: only while the system bus is ready; held off during reset.
    always_comb begin
        issue_c    = 1'b0;
        issue_id_c = 1'b0;
        if (HRESETn && HREADY_S && (req_c != 2'b00)) begin
            issue_c = 1'b1;
            if (req_c == 2'b11) begin
                issue_id_c = (ARB_MODE == 0) ? 1'b0 : ~last_grant_q;
            end else begin
                issue_id_c = req_c[1];
            end
        end
    end

    // Shared address phase: pend buffer has precedence over the live inputs.
    always_comb begin
        sel_c = live_c[0];
        if (issue_c) begin
            sel_c = pend_valid_q[issue_id_c] ? pend_q[issue_id_c] : live_c[issue_id_c];
        end
    end

    assign HADDR_S   = sel_c.addr;
    assign HWRITE_S  = sel_c.write;
    assign HSIZE_S   = sel_c.size;
    assign HTRANS_S  = issue_c ? 2'b10 : 2'b00;
    assign HWDATA_S  = (owner_q == OWN_M1) ? HWDATA_M1 : HWDATA_M0;
    assign HRDATA_M0 = HRDATA_S;
    assign HRDATA_M1 = HRDATA_S;
    assign HMASTER_S = (owner_q == OWN_M1);
    assign HREADY_M0 = hready_m_c[0];
    assign HREADY_M1 = hready_m_c[1];

    // Pend buffers: capture an accepted but not issued transfer, clear on issue.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            pend_valid_q <= 2'b00;
            pend_q[0]    <= '0;
            pend_q[1]    <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (issue_c && (issue_id_c == 1'(i))) begin
                    pend_valid_q[i] <= 1'b0;
                end else if (acc_c[i]) begin
                    pend_valid_q[i] <= 1'b1;
                    pend_q[i]       <= live_c[i];
                end
            end
        end
    end

    // Data-phase owner advances with HREADY_S; round-robin history on issue.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            owner_q      <= OWN_NONE;
            last_grant_q <= 1'b1;
        end else begin
            if (HREADY_S) begin
                owner_q <= issue_c ? (issue_id_c ? OWN_M1 : OWN_M0) : OWN_NONE;
            end
            if (issue_c) begin
                last_grant_q <= issue_id_c;
            end
        end
    end

endmodule

// File: tb/tb_ahb_master_arbiter_2x1.sv
// Directed bench for ahb_master_arbiter_2x1: one fixed-priority and one
// round-robin instance share the same master/slave stimulus.
module tb_ahb_master_arbiter_2x1;

    logic        HCLK;
    logic        HRESETn;
    logic [31:0] HADDR_M0, HADDR_M1;
    logic [1:0]  HTRANS_M0, HTRANS_M1;
    logic        HWRITE_M0, HWRITE_M1;
    logic [2:0]  HSIZE_M0, HSIZE_M1;
    logic [63:0] HWDATA_M0, HWDATA_M1;
    logic        HREADY_S;
    logic [63:0] HRDATA_S;

    logic        fp_hready_m0, fp_hready_m1, rr_hready_m0, rr_hready_m1;
    logic [63:0] fp_hrdata_m0, fp_hrdata_m1, rr_hrdata_m0, rr_hrdata_m1;
    logic [31:0] fp_haddr_s, rr_haddr_s;
    logic [1:0]  fp_htrans_s, rr_htrans_s;
    logic        fp_hwrite_s, rr_hwrite_s;
    logic [2:0]  fp_hsize_s, rr_hsize_s;
    logic [63:0] fp_hwdata_s, rr_hwdata_s;
    logic        fp_hmaster_s, rr_hmaster_s;

    int total = 0;
    int bad   = 0;

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    ahb_master_arbiter_2x1 #(.AW(32), .DW(64), .ARB_MODE(0)) dut_fp (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .HADDR_M0(HADDR_M0), .HTRANS_M0(HTRANS_M0), .HWRITE_M0(HWRITE_M0),
        .HSIZE_M0(HSIZE_M0), .HWDATA_M0(HWDATA_M0),
        .HREADY_M0(fp_hready_m0), .HRDATA_M0(fp_hrdata_m0),
        .HADDR_M1(HADDR_M1), .HTRANS_M1(HTRANS_M1), .HWRITE_M1(HWRITE_M1),
        .HSIZE_M1(HSIZE_M1), .HWDATA_M1(HWDATA_M1),
        .HREADY_M1(fp_hready_m1), .HRDATA_M1(fp_hrdata_m1),
        .HADDR_S(fp_haddr_s), .HTRANS_S(fp_htrans_s), .HWRITE_S(fp_hwrite_s),
        .HSIZE_S(fp_hsize_s), .HWDATA_S(fp_hwdata_s),
        .HREADY_S(HREADY_S), .HRDATA_S(HRDATA_S), .HMASTER_S(fp_hmaster_s)
    );

    ahb_master_arbiter_2x1 #(.AW(32), .DW(64), .ARB_MODE(1)) dut_rr (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .HADDR_M0(HADDR_M0), .HTRANS_M0(HTRANS_M0), .HWRITE_M0(HWRITE_M0),
        .HSIZE_M0(HSIZE_M0), .HWDATA_M0(HWDATA_M0),
        .HREADY_M0(rr_hready_m0), .HRDATA_M0(rr_hrdata_m0),
        .HADDR_M1(HADDR_M1), .HTRANS_M1(HTRANS_M1), .HWRITE_M1(HWRITE_M1),
        .HSIZE_M1(HSIZE_M1), .HWDATA_M1(HWDATA_M1),
        .HREADY_M1(rr_hready_m1), .HRDATA_M1(rr_hrdata_m1),
        .HADDR_S(rr_haddr_s), .HTRANS_S(rr_htrans_s), .HWRITE_S(rr_hwrite_s),
        .HSIZE_S(rr_hsize_s), .HWDATA_S(rr_hwdata_s),
        .HREADY_S(HREADY_S), .HRDATA_S(HRDATA_S), .HMASTER_S(rr_hmaster_s)
    );

    // Compare one observed value against its hand-computed expectation.
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge, where inputs are driven.
    task automatic step;
        @(posedge HCLK);
        #1;
    endtask

    // Let combinational outputs settle; samples are taken on the falling edge.
    task automatic settle;
        @(negedge HCLK);
    endtask

    task automatic idle_masters;
        HTRANS_M0 = 2'b00; HADDR_M0 = 32'h0; HWRITE_M0 = 1'b0; HSIZE_M0 = 3'd0;
        HTRANS_M1 = 2'b00; HADDR_M1 = 32'h0; HWRITE_M1 = 1'b0; HSIZE_M1 = 3'd0;
    endtask

    task automatic m0_nonseq(input logic [31:0] addr, input logic wr, input logic [2:0] sz);
        HTRANS_M0 = 2'b10; HADDR_M0 = addr; HWRITE_M0 = wr; HSIZE_M0 = sz;
    endtask

    task automatic m1_nonseq(input logic [31:0] addr, input logic wr, input logic [2:0] sz);
        HTRANS_M1 = 2'b10; HADDR_M1 = addr; HWRITE_M1 = wr; HSIZE_M1 = sz;
    endtask

    initial begin
        // Reset with both masters driving NONSEQ
        HRESETn = 1'b0; HREADY_S = 1'b1; HRDATA_S = 64'h0;
        HWDATA_M0 = 64'h0; HWDATA_M1 = 64'h0;
        m0_nonseq(32'h0000_0100, 1'b0, 3'd2);
        m1_nonseq(32'h0000_0200, 1'b0, 3'd2);
        settle;
        chk("rst_fp_htrans", 64'(fp_htrans_s), 64'h0);
        chk("rst_rr_htrans", 64'(rr_htrans_s), 64'h0);
        chk("rst_fp_hready_m0", 64'(fp_hready_m0), 64'h1);
        chk("rst_fp_hready_m1", 64'(fp_hready_m1), 64'h1);
        chk("rst_rr_hready_m1", 64'(rr_hready_m1), 64'h1);
        chk("rst_fp_hmaster", 64'(fp_hmaster_s), 64'h0);
        chk("rst_fp_haddr", 64'(fp_haddr_s), 64'h100);

        step; HRESETn = 1'b1; idle_masters;

        // Round-robin contention
        step; m0_nonseq(32'h2000_0000, 1'b0, 3'd3); m1_nonseq(32'h2000_0008, 1'b1, 3'd2);
        settle;
        chk("c0_rr_htrans", 64'(rr_htrans_s), 64'h2);
        chk("c0_rr_haddr", 64'(rr_haddr_s), 64'h2000_0000);
        chk("c0_rr_hready_m1", 64'(rr_hready_m1), 64'h1);
        step; idle_masters;
        settle;
        chk("c1_rr_hready_m1", 64'(rr_hready_m1), 64'h0);
        chk("c1_rr_htrans", 64'(rr_htrans_s), 64'h2);
        chk("c1_rr_haddr", 64'(rr_haddr_s), 64'h2000_0008);
        chk("c1_rr_hwrite", 64'(rr_hwrite_s), 64'h1);
        chk("c1_rr_hsize", 64'(rr_hsize_s), 64'h2);
        chk("c1_rr_hmaster", 64'(rr_hmaster_s), 64'h0);
        step; HRDATA_S = 64'hCAFE_F00D_0123_4567;
        settle;
        chk("c2_rr_hmaster", 64'(rr_hmaster_s), 64'h1);
        chk("c2_rr_hready_m1", 64'(rr_hready_m1), 64'h1);
        chk("c2_rr_htrans", 64'(rr_htrans_s), 64'h0);
        chk("c2_rr_hrdata_m1", rr_hrdata_m1, 64'hCAFE_F00D_0123_4567);
        chk("c2_rr_hrdata_m0", rr_hrdata_m0, 64'hCAFE_F00D_0123_4567);
        step; m0_nonseq(32'h2000_0020, 1'b0, 3'd3); m1_nonseq(32'h2000_0028, 1'b0, 3'd3);
        settle;
        chk("c3_rr_haddr", 64'(rr_haddr_s), 64'h2000_0020);
        step; idle_masters; m0_nonseq(32'h2000_0030, 1'b0, 3'd3);
        settle;
        chk("c4_rr_haddr", 64'(rr_haddr_s), 64'h2000_0028);
        chk("c4_fp_haddr", 64'(fp_haddr_s), 64'h2000_0030);
        chk("c4_rr_hready_m1", 64'(rr_hready_m1), 64'h0);
        step; idle_masters;
        settle;
        chk("c5_rr_haddr", 64'(rr_haddr_s), 64'h2000_0030);
        chk("c5_rr_hready_m0", 64'(rr_hready_m0), 64'h0);
        chk("c5_rr_hmaster", 64'(rr_hmaster_s), 64'h1);
        chk("c5_fp_haddr", 64'(fp_haddr_s), 64'h2000_0028);
        chk("c5_fp_hready_m1", 64'(fp_hready_m1), 64'h0);
        chk("c5_fp_hmaster", 64'(fp_hmaster_s), 64'h0);
        step;
        settle;
        chk("c6_rr_hmaster", 64'(rr_hmaster_s), 64'h0);
        chk("c6_fp_hmaster", 64'(fp_hmaster_s), 64'h1);
        chk("c6_fp_htrans", 64'(fp_htrans_s), 64'h0);

        // Single-master write, zero wait states
        step; m0_nonseq(32'h2000_0010, 1'b1, 3'd3);
        settle;
        chk("w0_fp_haddr", 64'(fp_haddr_s), 64'h2000_0010);
        chk("w0_fp_htrans", 64'(fp_htrans_s), 64'h2);
        chk("w0_fp_hwrite", 64'(fp_hwrite_s), 64'h1);
        chk("w0_fp_hsize", 64'(fp_hsize_s), 64'h3);
        chk("w0_rr_haddr", 64'(rr_haddr_s), 64'h2000_0010);
        chk("w0_fp_hready_m1", 64'(fp_hready_m1), 64'h1);
        step; idle_masters; HWDATA_M0 = 64'h1122_3344_5566_7788; HWDATA_M1 = 64'hFFFF_0000_FFFF_0000;
        settle;
        chk("w1_fp_hwdata", fp_hwdata_s, 64'h1122_3344_5566_7788);
        chk("w1_rr_hwdata", rr_hwdata_s, 64'h1122_3344_5566_7788);
        chk("w1_fp_hmaster", 64'(fp_hmaster_s), 64'h0);
        chk("w1_fp_hready_m1", 64'(fp_hready_m1), 64'h1);

        // Slave wait states while M1 requests
        step; m0_nonseq(32'h2000_0040, 1'b0, 3'd3);
        settle;
        chk("ws0_rr_htrans", 64'(rr_htrans_s), 64'h2);
        step; idle_masters; HREADY_S = 1'b0; m1_nonseq(32'h2000_0048, 1'b0, 3'd3);
        settle;
        chk("ws1_rr_htrans", 64'(rr_htrans_s), 64'h0);
        chk("ws1_rr_hready_m0", 64'(rr_hready_m0), 64'h0);
        chk("ws1_rr_hready_m1", 64'(rr_hready_m1), 64'h1);
        step; idle_masters;
        settle;
        chk("ws2_rr_htrans", 64'(rr_htrans_s), 64'h0);
        chk("ws2_rr_hready_m0", 64'(rr_hready_m0), 64'h0);
        chk("ws2_rr_hready_m1", 64'(rr_hready_m1), 64'h0);
        chk("ws2_fp_hready_m1", 64'(fp_hready_m1), 64'h0);
        step; HREADY_S = 1'b1;
        settle;
        chk("ws3_rr_htrans", 64'(rr_htrans_s), 64'h2);
        chk("ws3_rr_haddr", 64'(rr_haddr_s), 64'h2000_0048);
        chk("ws3_rr_hready_m0", 64'(rr_hready_m0), 64'h1);
        chk("ws3_fp_haddr", 64'(fp_haddr_s), 64'h2000_0048);
        step;
        settle;
        chk("ws4_rr_hmaster", 64'(rr_hmaster_s), 64'h1);
        chk("ws4_fp_hmaster", 64'(fp_hmaster_s), 64'h1);

        // Fixed-priority starvation: five back-to-back M0 transfers
        step; m0_nonseq(32'h2000_0100, 1'b0, 3'd3); m1_nonseq(32'h2000_0200, 1'b0, 3'd3);
        settle;
        chk("s0_fp_haddr", 64'(fp_haddr_s), 64'h2000_0100);
        step; idle_masters; m0_nonseq(32'h2000_0108, 1'b0, 3'd3);
        settle;
        chk("s1_fp_haddr", 64'(fp_haddr_s), 64'h2000_0108);
        chk("s1_fp_hready_m1", 64'(fp_hready_m1), 64'h0);
        chk("s1_rr_haddr", 64'(rr_haddr_s), 64'h2000_0200);
        for (int i = 2; i < 5; i++) begin
            step; m0_nonseq(32'h2000_0100 + 32'(8 * i), 1'b0, 3'd3);
            settle;
            chk($sformatf("s%0d_fp_haddr", i), 64'(fp_haddr_s), 64'(32'h2000_0100 + 32'(8 * i)));
            chk($sformatf("s%0d_fp_hready_m1", i), 64'(fp_hready_m1), 64'h0);
        end
        step; idle_masters;
        settle;
        chk("s5_fp_haddr", 64'(fp_haddr_s), 64'h2000_0200);
        chk("s5_fp_htrans", 64'(fp_htrans_s), 64'h2);
        chk("s5_fp_hready_m1", 64'(fp_hready_m1), 64'h0);
        step;
        settle;
        chk("s6_fp_hmaster", 64'(fp_hmaster_s), 64'h1);
        chk("s6_fp_hready_m1", 64'(fp_hready_m1), 64'h1);

        // Reset while M1 has a pending transfer
        step; m0_nonseq(32'h2000_0050, 1'b0, 3'd3); m1_nonseq(32'h2000_0058, 1'b0, 3'd3);
        settle;
        chk("r0_fp_haddr", 64'(fp_haddr_s), 64'h2000_0050);
        step; idle_masters;
        settle;
        chk("r1_fp_hready_m1", 64'(fp_hready_m1), 64'h0);
        chk("r1_fp_htrans", 64'(fp_htrans_s), 64'h2);
        #2; HRESETn = 1'b0;
        #1;
        chk("r2_fp_hready_m1", 64'(fp_hready_m1), 64'h1);
        chk("r2_fp_htrans", 64'(fp_htrans_s), 64'h0);
        chk("r2_rr_hready_m1", 64'(rr_hready_m1), 64'h1);
        chk("r2_rr_hready_m0", 64'(rr_hready_m0), 64'h1);
        step; HRESETn = 1'b1;
        settle;
        chk("r3_fp_htrans", 64'(fp_htrans_s), 64'h0);
        chk("r3_rr_htrans", 64'(rr_htrans_s), 64'h0);
        chk("r3_fp_hready_m1", 64'(fp_hready_m1), 64'h1);
        step;
        settle;
        chk("r4_fp_htrans", 64'(fp_htrans_s), 64'h0);
        chk("r4_fp_hmaster", 64'(fp_hmaster_s), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ahb_master_arbiter_2x1.md
# ahb_master_arbiter_2x1

Two-master AHB-Lite arbiter that lets a second bus master (DMA or debug) share the single AHB-Lite slave path into the system bus alongside the EL2 core. It sits between the two masters and the system bus, which carries QSPI flash, SRAM, GPIO and the APB bridge. Each master sees a private AHB-Lite slave port. The arbiter buffers a losing master's address phase, stalls that master via its HREADY, and replays the transfer on the shared port.

## Interface
- AW, 32, address width
- DW, 64, data width
- ARB_MODE, 1, arbitration policy: 0 = fixed priority with M0 highest, 1 = round-robin

- HCLK  in  1  bus clock; the only clock
- HRESETn  in  1  asynchronous, active-low reset
- HADDR_M0 / HADDR_M1  in  AW  master address
- HTRANS_M0 / HTRANS_M1  in  2  master transfer type
- HWRITE_M0 / HWRITE_M1  in  1  master write flag
- HSIZE_M0 / HSIZE_M1  in  3  master transfer size
- HWDATA_M0 / HWDATA_M1  in  DW  master write data
- HREADY_M0 / HREADY_M1  out  1  ready returned to each master
- HRDATA_M0 / HRDATA_M1  out  DW  read data returned to each master
- HADDR_S  out  AW  shared-port address
- HTRANS_S  out  2  shared-port transfer type
- HWRITE_S  out  1  shared-port write flag
- HSIZE_S  out  3  shared-port transfer size
- HWDATA_S  out  DW  shared-port write data
- HREADY_S  in  1  ready from the system bus
- HRDATA_S  in  DW  read data from the system bus
- HMASTER_S  out  1  owner of the current data phase (0 = M0, 1 = M1)

## Operation
- **Transfer validity.** A master transfer is valid when HTRANS_Mx[1]=1. IDLE and BUSY are both ignored.
- **Acceptance.** The arbiter accepts master x's address phase at any edge where HTRANS_Mx[1]=1 and HREADY_Mx=1.
- **Pending buffer.** Per master: pend_valid_x plus registered HADDR, HWRITE and HSIZE.
  - Loaded on acceptance unless the transfer is issued directly at that same edge.
  - Cleared when the pending transfer is issued.
- **Request.** req_x = pend_valid_x | (HTRANS_Mx[1] & HREADY_Mx).
- **Grant.** Evaluated only in cycles where HREADY_S=1.
  - ARB_MODE=0: M0 wins whenever it requests.
  - ARB_MODE=1: on contention, the master not in last_grant wins. last_grant updates on every issue.
- **Shared address outputs.**
  - Granted master: HADDR/HWRITE/HSIZE come from its pend registers if pend_valid_x, otherwise from its live inputs.
  - HTRANS_S = 2'b10 (NONSEQ) for every issued transfer; SEQ is never forwarded.
  - No grant, or HREADY_S=0: HTRANS_S = 2'b00. HADDR/HWRITE/HSIZE then follow M0's live inputs.
- **Data-phase owner.** data_owner ∈ {NONE, M0, M1}.
  - On an edge with HREADY_S=1, it loads the issued master, or NONE if nothing was issued.
  - It holds while HREADY_S=0.
- **Data muxing.**
  - HWDATA_S = HWDATA of data_owner (M0 when NONE).
  - HRDATA_M0 = HRDATA_M1 = HRDATA_S.
  - HMASTER_S = 1 only when data_owner = M1.
- **Ready to masters.** HREADY_Mx = HREADY_S if data_owner = x; else ~pend_valid_x.
- **Invariant.** pend_valid_x and data_owner = x are never both true.
- **Write data with a pending transfer.** A pending master holds its HWDATA stable, because its HREADY is low. That held data is used when its data phase later runs on the shared port.

## Timing
- **Reset values** (async): pend_valid_0/1=0, data_owner=NONE, last_grant=M1, pend registers=0. Resulting outputs:
  - HTRANS_S=00
  - HREADY_M0=HREADY_M1=1
  - HMASTER_S=0
  - HADDR_S/HWRITE_S/HSIZE_S follow M0's live inputs.
- **Direct path.** The winning live master adds zero latency: its address reaches HADDR_S combinationally in the same cycle, and its data phase starts the next cycle.
- **Losing or stalled master.**
  - Captured at the accepting edge; HREADY_Mx=0 from the following cycle.
  - Issued at the first HREADY_S=1 cycle in which it wins.
  - HREADY_Mx then tracks HREADY_S through its data phase.
- **Round-robin bound.** A pending master waits at most one foreign transfer plus that transfer's wait states.
- **Fixed-priority mode.** M1 may starve indefinitely.
- **Wait states.** While HREADY_S=0, no new address is issued. A valid transfer accepted from the non-owner during that time goes to its pend buffer.
- **Simultaneous events.** Capture and clear on the same master in the same cycle cannot occur, because HREADY_Mx=0 while pending.
- **Reset mid-transfer.** Any in-flight or pending transfer is dropped. The slaves are reset by the same HRESETn.

## Test plan
- **Reset.** Hold HRESETn=0 with both masters driving NONSEQ -> HTRANS_S=00, HREADY_M0=HREADY_M1=1, HMASTER_S=0.
- **Single-master write.** M0 writes 0x2000_0010, HSIZE=3, data 0x1122334455667788, zero wait states:
  - HADDR_S=0x2000_0010 with HTRANS_S=10 in the same cycle.
  - HWDATA_S=0x1122334455667788 and HMASTER_S=0 in the next cycle.
  - HREADY_M1 stays 1 throughout.
- **Contention, ARB_MODE=1.** Both issue NONSEQ in cycle 0 (M0 → 0x2000_0000, M1 → 0x2000_0008):
  - Cycle 0: M0 issued.
  - Cycle 1: HREADY_M1=0; M1 issued from pend with HADDR_S=0x2000_0008.
  - Cycle 2: HMASTER_S=1.
  - The next contention is won by M0.
- **Slave wait states.** HREADY_S=0 for 2 cycles during M0's data phase while M1 requests:
  - HTRANS_S=00 during both wait cycles; M1 is captured.
  - M1 is issued in the cycle HREADY_S returns to 1.
  - HREADY_M0 mirrors HREADY_S.
- **Starvation, ARB_MODE=0.** M0 issues back-to-back NONSEQ for 5 transfers while M1 requests:
  - HREADY_M1=0 throughout.
  - M1 is issued in the first cycle M0 is IDLE.
- **Reset with a pending transfer.** Assert HRESETn while pend_valid_1=1 -> HREADY_M1=1 immediately (asynchronously), and no M1 transfer appears on HTRANS_S after reset release.
